// File: rtl/riscv_pkg.sv
// Shared RV64 core constants and types used by the write-back/register-file slice.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_X0 = 5'd0;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One decode-stage read port: x0 forced to zero, same-cycle write bypass, else storage.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG,
  parameter int AW   = riscv_pkg::AW
) (
  input  logic [AW-1:0]   addr,
  input  logic            commit,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] regs [NREG],
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = regs[addr];
    if (addr == REG_X0) begin
      rdata = '0;
    end else if (commit && (addr == wb_rd)) begin
      rdata = wb_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result, commits it to the integer register file,
// serves two bypassed read ports and counts committed writes.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG,
  parameter int AW   = riscv_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] wb_readdata,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_memtoreg,
  input  logic            wb_regwrite,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic [63:0]     wb_count
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [63:0]     wb_count_reg;
  logic            commit;

  logic [AW-1:0]   port_addr [2];
  logic [XLEN-1:0] port_data [2];

  assign wb_data  = wb_memtoreg ? wb_readdata : wb_alu_result;
  assign commit   = wb_regwrite && (wb_rd != REG_X0);
  assign wb_count = wb_count_reg;

  // Entry 0 is held at zero so it never carries state; the read mux masks it anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
      wb_count_reg <= '0;
    end else begin
      regs_reg[0] <= '0;
      if (commit) begin
        regs_reg[wb_rd] <= wb_data;
        wb_count_reg    <= wb_count_reg + 64'd1;
      end
    end
  end

  assign port_addr[0] = rs1_addr;
  assign port_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      regfile_read_port #(
        .XLEN(XLEN),
        .NREG(NREG),
        .AW  (AW)
      ) u_port (
        .addr   (port_addr[gi]),
        .commit (commit),
        .wb_rd  (wb_rd),
        .wb_data(wb_data),
        .regs   (regs_reg),
        .rdata  (port_data[gi])
      );
    end
  endgenerate

  assign rs1_data = port_data[0];
  assign rs2_data = port_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; inputs change and outputs are sampled on negedge.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [63:0] wb_readdata;
  logic [63:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic        wb_memtoreg;
  logic        wb_regwrite;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] wb_data;
  logic [63:0] wb_count;

  int tests_run;
  int tests_failed;

  wb_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .wb_readdata  (wb_readdata),
    .wb_alu_result(wb_alu_result),
    .wb_rd        (wb_rd),
    .wb_memtoreg  (wb_memtoreg),
    .wb_regwrite  (wb_regwrite),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_data      (wb_data),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wb_regwrite   = 1'b0;
    wb_memtoreg   = 1'b0;
    wb_rd         = 5'd0;
    wb_readdata   = 64'd0;
    wb_alu_result = 64'd0;
  endtask

  // Advance one full cycle: the rising edge happens between the two negedges.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    tests_run++;
    if (rs1_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_rs1 got=%h exp=%h", rs1_data, 64'd0);
    end
    tests_run++;
    if (rs2_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_rs2 got=%h exp=%h", rs2_data, 64'd0);
    end
    tests_run++;
    if (wb_count !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_count got=%0d exp=0", wb_count);
    end
    $display("[TB] reset: rs1=%h rs2=%h count=%0d", rs1_data, rs2_data, wb_count);
  endtask

  task automatic test_bypass();
    wb_regwrite   = 1'b1;
    wb_memtoreg   = 1'b0;
    wb_rd         = 5'd5;
    wb_alu_result = 64'h1234;
    wb_readdata   = 64'hBAD0;
    rs1_addr      = 5'd5;
    rs2_addr      = 5'd6;
    #1;
    tests_run++;
    if (rs1_data !== 64'h1234) begin
      tests_failed++;
      $display("FAIL bypass_rs1 got=%h exp=%h", rs1_data, 64'h1234);
    end
    tests_run++;
    if (rs2_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL bypass_rs2_other got=%h exp=%h", rs2_data, 64'd0);
    end
    next_cycle();
    idle_inputs();
    #1;
    tests_run++;
    if (rs1_data !== 64'h1234) begin
      tests_failed++;
      $display("FAIL storage_rs1 got=%h exp=%h", rs1_data, 64'h1234);
    end
    tests_run++;
    if (wb_count !== 64'd1) begin
      tests_failed++;
      $display("FAIL bypass_count got=%0d exp=1", wb_count);
    end
    $display("[TB] bypass write x5=0x1234: rs1=%h count=%0d", rs1_data, wb_count);
  endtask

  task automatic test_x0_write();
    wb_regwrite   = 1'b1;
    wb_rd         = 5'd0;
    wb_alu_result = 64'hDEAD;
    rs1_addr      = 5'd0;
    #1;
    tests_run++;
    if (rs1_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL x0_same_cycle got=%h exp=%h", rs1_data, 64'd0);
    end
    next_cycle();
    idle_inputs();
    #1;
    tests_run++;
    if (rs1_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL x0_next_cycle got=%h exp=%h", rs1_data, 64'd0);
    end
    tests_run++;
    if (wb_count !== 64'd1) begin
      tests_failed++;
      $display("FAIL x0_count got=%0d exp=1", wb_count);
    end
    $display("[TB] x0 write 0xDEAD: rs1=%h count=%0d", rs1_data, wb_count);
  endtask

  task automatic test_memtoreg();
    wb_regwrite   = 1'b1;
    wb_memtoreg   = 1'b1;
    wb_rd         = 5'd7;
    wb_readdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    wb_alu_result = 64'h1;
    rs1_addr      = 5'd7;
    rs2_addr      = 5'd7;
    #1;
    tests_run++;
    if (wb_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++;
      $display("FAIL memtoreg_wb_data got=%h exp=%h", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    tests_run++;
    if (rs1_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++;
      $display("FAIL memtoreg_rs1 got=%h exp=%h", rs1_data, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    tests_run++;
    if (rs2_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++;
      $display("FAIL memtoreg_rs2 got=%h exp=%h", rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    next_cycle();
    idle_inputs();
    wb_alu_result = 64'h42;
    #1;
    tests_run++;
    if (wb_data !== 64'h42) begin
      tests_failed++;
      $display("FAIL alu_select_wb_data got=%h exp=%h", wb_data, 64'h42);
    end
    tests_run++;
    if (rs1_data !== 64'hFFFF_FFFF_FFFF_FFFF || rs2_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++;
      $display("FAIL memtoreg_storage got=%h/%h exp=%h", rs1_data, rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    tests_run++;
    if (wb_count !== 64'd2) begin
      tests_failed++;
      $display("FAIL memtoreg_count got=%0d exp=2", wb_count);
    end
    $display("[TB] load write x7: rs1=%h rs2=%h count=%0d", rs1_data, rs2_data, wb_count);
  endtask

  task automatic test_reset_with_commit();
    reset         = 1'b1;
    wb_regwrite   = 1'b1;
    wb_memtoreg   = 1'b0;
    wb_rd         = 5'd9;
    wb_alu_result = 64'h55;
    rs1_addr      = 5'd9;
    rs2_addr      = 5'd5;
    #1;
    tests_run++;
    if (wb_data !== 64'h55) begin
      tests_failed++;
      $display("FAIL reset_wb_data got=%h exp=%h", wb_data, 64'h55);
    end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    #1;
    tests_run++;
    if (rs1_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_wins_x9 got=%h exp=%h", rs1_data, 64'd0);
    end
    tests_run++;
    if (rs2_data !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_cleared_x5 got=%h exp=%h", rs2_data, 64'd0);
    end
    tests_run++;
    if (wb_count !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_wins_count got=%0d exp=0", wb_count);
    end
    wb_regwrite   = 1'b1;
    wb_rd         = 5'd9;
    wb_alu_result = 64'h77;
    next_cycle();
    idle_inputs();
    #1;
    tests_run++;
    if (rs1_data !== 64'h77) begin
      tests_failed++;
      $display("FAIL post_reset_write got=%h exp=%h", rs1_data, 64'h77);
    end
    tests_run++;
    if (wb_count !== 64'd1) begin
      tests_failed++;
      $display("FAIL post_reset_count got=%0d exp=1", wb_count);
    end
    $display("[TB] reset+commit then write x9=0x77: rs1=%h count=%0d", rs1_data, wb_count);
  endtask

  task automatic test_back_to_back();
    logic [63:0] expected [32];
    logic [4:0]  rd;
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    for (int r = 0; r < 32; r++) expected[r] = 64'd0;
    for (int i = 0; i < 40; i++) begin
      rd            = 5'((i % 31) + 1);
      wb_regwrite   = 1'b1;
      wb_memtoreg   = i[0];
      wb_rd         = rd;
      wb_readdata   = 64'hC000_0000_0000_0000 | (64'(i) << 8) | 64'(rd);
      wb_alu_result = 64'hA000_0000_0000_0000 | (64'(i) << 8) | 64'(rd);
      expected[rd]  = i[0] ? wb_readdata : wb_alu_result;
      next_cycle();
    end
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r);
      rs2_addr = 5'(32 - r);
      #1;
      tests_run++;
      if (rs1_data !== expected[r] || rs2_data !== expected[32 - r]) begin
        tests_failed++;
        $display("FAIL b2b_read x%0d got=%h/%h exp=%h/%h", r, rs1_data, rs2_data,
                 expected[r], expected[32 - r]);
      end
      $display("[TB] b2b read x%0d=%h x%0d=%h", r, rs1_data, 32 - r, rs2_data);
    end
    tests_run++;
    if (wb_count !== 64'd40) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d exp=40", wb_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    rs1_addr     = 5'd0;
    rs2_addr     = 5'd0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_x0_write();
    test_memtoreg();
    test_reset_with_commit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
